// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
//   Execute stage of the 5-stage ARM-subset pipeline. Sits directly after the
//   ID/EX register: picks forwarded operands, builds Val2 (rotated immediate,
//   shifted register or memory offset), runs the ALU, keeps the NZCV status
//   register and computes the branch target. Results go into an internal
//   EX/MEM register that feeds the memory stage.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   freeze              memory-stall hold for EX/MEM and status registers
//   pcIn                PC+4 of the instruction in EX
//   aluCmdIn            4-bit ALU command
//   memReadIn/memWriteIn/wbEnIn/branchIn/sIn   control bits
//   reg1In, reg2In      Rn / Rm as read in ID
//   immIn               immediate-operand flag
//   shiftOperandIn      12-bit shifter operand / memory offset
//   imm24In             signed branch offset in words
//   destIn              destination register number
//   sel1, sel2          forward selects (0/3 = reg, 1 = fwdMem, 2 = fwdWb)
//   fwdMem, fwdWb       forwarded values from MEM and WB
//   branchTaken         combinational copy of branchIn
//   branchAddr          combinational pcIn + sext(imm24In)*4
//   status              registered NZCV (bit 3 = N)
//   aluResOut, valRmOut, destOut, memReadOut, memWriteOut, wbEnOut
//                       EX/MEM register outputs
// -----------------------------------------------------------------------------
module exe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic [WIDTH-1:0] pcIn,
    input  logic [3:0]       aluCmdIn,
    input  logic             memReadIn,
    input  logic             memWriteIn,
    input  logic             wbEnIn,
    input  logic             branchIn,
    input  logic             sIn,
    input  logic [WIDTH-1:0] reg1In,
    input  logic [WIDTH-1:0] reg2In,
    input  logic             immIn,
    input  logic [11:0]      shiftOperandIn,
    input  logic [23:0]      imm24In,
    input  logic [3:0]       destIn,
    input  logic [1:0]       sel1,
    input  logic [1:0]       sel2,
    input  logic [WIDTH-1:0] fwdMem,
    input  logic [WIDTH-1:0] fwdWb,
    output logic             branchTaken,
    output logic [WIDTH-1:0] branchAddr,
    output logic [3:0]       status,
    output logic [WIDTH-1:0] aluResOut,
    output logic [WIDTH-1:0] valRmOut,
    output logic [3:0]       destOut,
    output logic             memReadOut,
    output logic             memWriteOut,
    output logic             wbEnOut
);

    typedef enum logic [3:0] {
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } alu_cmd_e;

    logic [31:0] r_alu_res, r_val_rm;
    logic [3:0]  r_dest, r_status;
    logic        r_mem_read, r_mem_write, r_wb_en;

    logic [31:0] w_op_a, w_rm, w_val2, w_imm8, w_imm_rot, w_rm_ror;
    logic [4:0]  w_rot_amt, w_shamt;
    logic [31:0] w_op_b, w_res;
    logic        w_cin, w_is_sub;
    logic [32:0] w_sum;
    logic [3:0]  w_nzcv;

    // ---------------- branch (combinational) ----------------
    assign branchTaken = branchIn;
    assign branchAddr  = pcIn + {{6{imm24In[23]}}, imm24In, 2'b00};

    // ---------------- forwarding ----------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_op_a = reg1In;
        w_rm   = reg2In;
        case (sel1)
            2'd1:    w_op_a = fwdMem;
            2'd2:    w_op_a = fwdWb;
            default: w_op_a = reg1In;
        endcase
        case (sel2)
            2'd1:    w_rm = fwdMem;
            2'd2:    w_rm = fwdWb;
            default: w_rm = reg2In;
        endcase
    end

    // ---------------- Val2 generation ----------------
    // Rotates are built as (x >> n) | (x << (32-n)); a left shift by 32 yields 0,
    // so n = 0 degenerates cleanly to x.
    assign w_imm8    = {24'b0, shiftOperandIn[7:0]};
    assign w_rot_amt = {shiftOperandIn[11:8], 1'b0};
    assign w_imm_rot = (w_imm8 >> w_rot_amt) | (w_imm8 << (6'd32 - {1'b0, w_rot_amt}));
    assign w_shamt   = shiftOperandIn[11:7];
    assign w_rm_ror  = (w_rm >> w_shamt) | (w_rm << (6'd32 - {1'b0, w_shamt}));

    always_comb begin
        w_val2 = w_rm;
        if (memReadIn || memWriteIn) begin
            w_val2 = {20'b0, shiftOperandIn};
        end else if (immIn) begin
            w_val2 = w_imm_rot;
        end else if (w_shamt != 5'd0) begin
            case (shiftOperandIn[6:5])
                2'b00:   w_val2 = w_rm << w_shamt;
                2'b01:   w_val2 = w_rm >> w_shamt;
                2'b10:   w_val2 = 32'($signed(w_rm) >>> w_shamt);
                default: w_val2 = w_rm_ror;
            endcase
        end
    end

    // ---------------- ALU ----------------
    // All four arithmetic ops share one adder: subtraction is A + ~B + cin, so the
    // adder carry-out is directly ARM's NOT-borrow carry.
    always_comb begin
        w_is_sub = (aluCmdIn == CMD_SUB) || (aluCmdIn == CMD_SBC);
        w_op_b   = w_is_sub ? ~w_val2 : w_val2;
        case (aluCmdIn)
            CMD_ADC, CMD_SBC: w_cin = r_status[1];
            CMD_SUB:          w_cin = 1'b1;
            default:          w_cin = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_op_a} + {1'b0, w_op_b} + {32'b0, w_cin};

    always_comb begin
        w_res  = 32'b0;
        w_nzcv = r_status;
        case (aluCmdIn)
            CMD_MOV: w_res = w_val2;
            CMD_MVN: w_res = ~w_val2;
            CMD_AND: w_res = w_op_a & w_val2;
            CMD_ORR: w_res = w_op_a | w_val2;
            CMD_EOR: w_res = w_op_a ^ w_val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                w_res     = w_sum[31:0];
                w_nzcv[1] = w_sum[32];
                // overflow: both adder inputs share a sign that the result lacks
                w_nzcv[0] = (w_op_a[31] == w_op_b[31]) && (w_sum[31] != w_op_a[31]);
            end
            default: w_res = 32'b0;
        endcase
        // undefined commands leave all four flags as they were
        if (aluCmdIn inside {CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR,
                             CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC}) begin
            w_nzcv[3] = w_res[31];
            w_nzcv[2] = (w_res == 32'b0);
        end
    end

    // ---------------- EX/MEM and status registers ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_alu_res   <= '0;
            r_val_rm    <= '0;
            r_dest      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_wb_en     <= 1'b0;
            r_status    <= '0;
        end else if (!freeze) begin
            r_alu_res   <= w_res;
            r_val_rm    <= w_rm;
            r_dest      <= destIn;
            r_mem_read  <= memReadIn;
            r_mem_write <= memWriteIn;
            r_wb_en     <= wbEnIn;
            if (sIn) begin
                r_status <= w_nzcv;
            end
        end
    end

    assign status      = r_status;
    assign aluResOut   = r_alu_res;
    assign valRmOut    = r_val_rm;
    assign destOut     = r_dest;
    assign memReadOut  = r_mem_read;
    assign memWriteOut = r_mem_write;
    assign wbEnOut     = r_wb_en;

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
//   Self-checking bench for exe_stage: directed scenarios followed by random
//   stimulus, compared against an arithmetic reference model of the execute
//   stage (operand select, Val2, ALU flags, EX/MEM and status registers).
// -----------------------------------------------------------------------------
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic [31:0] pcIn, reg1In, reg2In, fwdMem, fwdWb;
    logic [3:0]  aluCmdIn, destIn;
    logic        memReadIn, memWriteIn, wbEnIn, branchIn, sIn, immIn;
    logic [11:0] shiftOperandIn;
    logic [23:0] imm24In;
    logic [1:0]  sel1, sel2;
    logic        branchTaken;
    logic [31:0] branchAddr, aluResOut, valRmOut;
    logic [3:0]  status, destOut;
    logic        memReadOut, memWriteOut, wbEnOut;

    always #5 clk = ~clk;

    exe_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .pcIn(pcIn), .aluCmdIn(aluCmdIn),
        .memReadIn(memReadIn), .memWriteIn(memWriteIn), .wbEnIn(wbEnIn),
        .branchIn(branchIn), .sIn(sIn), .reg1In(reg1In), .reg2In(reg2In),
        .immIn(immIn), .shiftOperandIn(shiftOperandIn), .imm24In(imm24In),
        .destIn(destIn), .sel1(sel1), .sel2(sel2), .fwdMem(fwdMem), .fwdWb(fwdWb),
        .branchTaken(branchTaken), .branchAddr(branchAddr), .status(status),
        .aluResOut(aluResOut), .valRmOut(valRmOut), .destOut(destOut),
        .memReadOut(memReadOut), .memWriteOut(memWriteOut), .wbEnOut(wbEnOut)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_alu, m_valrm;
    logic [3:0]  m_dest, m_status;
    logic        m_mr, m_mw, m_wb;

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] r);
        if (sel == 2'd1) return fwdMem;
        if (sel == 2'd2) return fwdWb;
        return r;
    endfunction

    // one bit position at a time, exactly as the shift types are defined
    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int n, input int kind);
        logic [31:0] y = x;
        for (int i = 0; i < n; i++) begin
            case (kind)
                0:       y = {y[30:0], 1'b0};
                1:       y = {1'b0, y[31:1]};
                2:       y = {y[31], y[31:1]};
                default: y = {y[0], y[31:1]};
            endcase
        end
        return y;
    endfunction

    function automatic logic [31:0] ref_val2(input logic [31:0] rm);
        if (memReadIn || memWriteIn) return {20'b0, shiftOperandIn};
        if (immIn) return ref_shift({24'b0, shiftOperandIn[7:0]}, 2 * int'(shiftOperandIn[11:8]), 3);
        return ref_shift(rm, int'(shiftOperandIn[11:7]), int'(shiftOperandIn[6:5]));
    endfunction

    task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] cmd,
                           input logic [3:0] st, output logic [31:0] res, output logic [3:0] nzcv);
        longint ua, ub, sa, sb, full, sres, cin;
        logic   arith;
        ua = longint'(a);  ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        cin = longint'(st[1]);
        nzcv = st;
        arith = 1'b0;
        full = 0; sres = 0;
        case (cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            4'b0010: begin arith = 1; full = ua + ub;       sres = sa + sb;       nzcv[1] = (full >= 64'sd4294967296); end
            4'b0011: begin arith = 1; full = ua + ub + cin; sres = sa + sb + cin; nzcv[1] = (full >= 64'sd4294967296); end
            4'b0100: begin arith = 1; full = ua - ub;       sres = sa - sb;       nzcv[1] = (ua >= ub); end
            4'b0101: begin arith = 1; full = ua - ub - (1 - cin); sres = sa - sb - (1 - cin);
                           nzcv[1] = (ua >= ub + (1 - cin)); end
            default: begin res = 32'b0; return; end
        endcase
        if (arith) begin
            res = full[31:0];
            nzcv[0] = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        end
        nzcv[3] = res[31];
        nzcv[2] = (res == 32'b0);
    endtask

    // Checks the combinational branch outputs, advances one clock, updates the
    // model and checks every registered output.
    task automatic cycle(input string tag);
        logic [31:0] a, rm, v2, res, exp_ba;
        logic [3:0]  nz;
        #1;
        exp_ba = pcIn + 32'(longint'($signed(imm24In)) * 4);
        check({tag, ".branchTaken"}, 32'(branchTaken), 32'(branchIn));
        check({tag, ".branchAddr"}, branchAddr, exp_ba);
        a  = ref_fwd(sel1, reg1In);
        rm = ref_fwd(sel2, reg2In);
        v2 = ref_val2(rm);
        ref_alu(a, v2, aluCmdIn, m_status, res, nz);
        if (rst) begin
            m_alu = '0; m_valrm = '0; m_dest = '0; m_mr = 0; m_mw = 0; m_wb = 0; m_status = '0;
        end else if (!freeze) begin
            m_alu = res; m_valrm = rm; m_dest = destIn;
            m_mr = memReadIn; m_mw = memWriteIn; m_wb = wbEnIn;
            if (sIn) m_status = nz;
        end
        @(posedge clk);
        #1;
        check({tag, ".aluResOut"}, aluResOut, m_alu);
        check({tag, ".valRmOut"}, valRmOut, m_valrm);
        check({tag, ".destOut"}, 32'(destOut), 32'(m_dest));
        check({tag, ".status"}, 32'(status), 32'(m_status));
        check({tag, ".ctrl"}, {29'b0, memReadOut, memWriteOut, wbEnOut}, {29'b0, m_mr, m_mw, m_wb});
    endtask

    task automatic drive_idle();
        rst = 0; freeze = 0; pcIn = 0; aluCmdIn = 0; memReadIn = 0; memWriteIn = 0;
        wbEnIn = 0; branchIn = 0; sIn = 0; reg1In = 0; reg2In = 0; immIn = 0;
        shiftOperandIn = 0; imm24In = 0; destIn = 0; sel1 = 0; sel2 = 0; fwdMem = 0; fwdWb = 0;
    endtask

    task automatic drive_random();
        pcIn = $urandom; aluCmdIn = 4'($urandom_range(0, 15));
        memReadIn = ($urandom_range(0, 7) == 0); memWriteIn = ($urandom_range(0, 7) == 0);
        wbEnIn = 1'($urandom); branchIn = 1'($urandom); sIn = 1'($urandom);
        reg1In = $urandom; reg2In = $urandom; immIn = 1'($urandom);
        shiftOperandIn = 12'($urandom); imm24In = 24'($urandom); destIn = 4'($urandom);
        sel1 = 2'($urandom); sel2 = 2'($urandom); fwdMem = $urandom; fwdWb = $urandom;
    endtask

    initial begin
        drive_idle();
        m_alu = '0; m_valrm = '0; m_dest = '0; m_mr = 0; m_mw = 0; m_wb = 0; m_status = '0;
        @(posedge clk); #1;

        // 1. reset with random inputs
        for (int i = 0; i < 2; i++) begin
            drive_random(); rst = 1; freeze = ($urandom_range(0, 1) == 1);
            cycle("reset");
        end
        check("reset.status0", 32'(status), 32'h0);
        check("reset.alu0", aluResOut, 32'h0);

        // 2. ADDS through MEM forwarding into signed overflow
        drive_idle();
        reg1In = 5; sel1 = 2'd1; fwdMem = 32'h7FFF_FFFF; immIn = 1; shiftOperandIn = 12'h001;
        aluCmdIn = 4'b0010; sIn = 1;
        cycle("adds");
        check("adds.res", aluResOut, 32'h8000_0000);
        check("adds.nzcv", 32'(status), 32'h9);

        // 3. SUBS to zero, then SBC consuming C=1
        drive_idle();
        reg1In = 3; immIn = 1; shiftOperandIn = 12'h003; aluCmdIn = 4'b0100; sIn = 1;
        cycle("subs");
        check("subs.res", aluResOut, 32'h0);
        check("subs.nzcv", 32'(status), 32'h6);
        reg1In = 10; shiftOperandIn = 12'h004; aluCmdIn = 4'b0101; sIn = 0;
        cycle("sbc");
        check("sbc.res", aluResOut, 32'h6);

        // 4. Val2 forms observed through MOV
        drive_idle();
        aluCmdIn = 4'b0001; immIn = 1; shiftOperandIn = 12'h4FF;
        cycle("immrot");
        check("immrot.val2", aluResOut, 32'hFF00_0000);
        immIn = 0; reg2In = 32'h8000_0000; shiftOperandIn = {5'd4, 2'b10, 1'b0, 4'd0};
        cycle("asr4");
        check("asr4.val2", aluResOut, 32'hF800_0000);
        reg2In = 32'h0000_00AB; shiftOperandIn = {5'd8, 2'b11, 1'b0, 4'd0};
        cycle("ror8");
        check("ror8.val2", aluResOut, 32'hAB00_0000);

        // 5. freeze for 3 cycles with changing inputs, including sIn=1
        for (int i = 0; i < 3; i++) begin
            drive_random(); freeze = 1; sIn = 1; rst = 0;
            cycle("freeze");
            check("freeze.alu_held", aluResOut, 32'hAB00_0000);
        end
        drive_random(); freeze = 0; rst = 0;
        cycle("release");

        // 6. branch target and LDR address
        drive_idle();
        pcIn = 32'h100; imm24In = 24'hFF_FFFE; branchIn = 1;
        memReadIn = 1; reg1In = 32'h400; shiftOperandIn = 12'h00C; aluCmdIn = 4'b0010;
        #1;
        check("branch.addr", branchAddr, 32'h0000_00F8);
        check("branch.taken", 32'(branchTaken), 32'h1);
        cycle("ldr");
        check("ldr.addr", aluResOut, 32'h0000_040C);
        check("ldr.memRead", 32'(memReadOut), 32'h1);

        // random phase with occasional freeze and reset
        for (int i = 0; i < 400; i++) begin
            drive_random();
            freeze = ($urandom_range(0, 9) == 0);
            rst    = ($urandom_range(0, 49) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
Execute stage of the 5-stage ARM-subset pipeline. It sits directly downstream of the ID/EX register and consumes its outputs. It applies operand forwarding, generates Val2 (immediate rotate, register shift, or memory offset), runs the ALU, holds the NZCV status register, and produces the branch target. Results are registered into an internal EX/MEM register that feeds the memory stage.

Parameters:
WIDTH, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  memory-stall hold; EX/MEM and status registers keep their values
pcIn  in  32  PC+4 of the instruction in EX
aluCmdIn  in  4  ALU command
memReadIn, memWriteIn, wbEnIn, branchIn, sIn  in  1 each  control bits
reg1In, reg2In  in  32  Rn / Rm values read in ID
immIn  in  1  immediate-operand flag
shiftOperandIn  in  12  shifter operand / memory offset
imm24In  in  24  signed branch offset (words)
destIn  in  4  destination register
sel1, sel2  in  2  forward select: 0 = regN, 1 = fwdMem, 2 = fwdWb, 3 = regN
fwdMem, fwdWb  in  32  forwarded values from MEM and WB
branchTaken  out  1  combinational: equals branchIn
branchAddr  out  32  combinational: pcIn + (sext(imm24In) << 2)
status  out  4  registered NZCV, bit 3 = N
aluResOut  out  32  registered ALU result / memory address
valRmOut  out  32  registered forwarded Rm (store data)
destOut  out  4  registered
memReadOut, memWriteOut, wbEnOut  out  1 each  registered

Behaviour:
- Reset (rst=1 at edge): every registered output and status = 0. rst has priority over freeze.
- Latency: 1 cycle, inputs to registered outputs. branchTaken and branchAddr are combinational, 0 cycles.
- Operand A = mux(sel1, reg1In). Operand Rm = mux(sel2, reg2In). valRmOut takes the forwarded Rm.
- Val2 selection, in priority order:
  - memReadIn|memWriteIn: zero-extended shiftOperandIn[11:0].
  - immIn: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Otherwise: Rm shifted by so[11:7], type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 means unshifted for every type.
- ALU commands, with carry-in C taken from status[1]:
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD: A+Val2
  - 0011 ADC: A+Val2+C
  - 0100 SUB/CMP: A-Val2
  - 0101 SBC: A-Val2-~C
  - 0110 AND/TST, 0111 ORR, 1000 EOR: bitwise operations
  - Any other code: result 0, flags unchanged.
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops: C = carry-out of the 33-bit sum (for subtraction, C = NOT borrow). V = signed overflow.
  - Logic and move ops: C and V keep their previous values.
- Status register: loads the new NZCV at the edge when sIn=1 and freeze=0; otherwise it holds. An instruction flushed upstream arrives with sIn=0 and therefore leaves status untouched.
- EX/MEM register: loads at every edge with freeze=0 and holds when freeze=1. It has no flush: branch flush is handled upstream.
- Simultaneous sIn=1 and freeze=1: status holds. The status update happens on the cycle the instruction leaves EX.
- Branch: branchAddr is computed every cycle and is valid only when branchTaken=1. Arithmetic wraps modulo 2^32.

Test Plan:
1. Reset: rst=1 for 2 cycles with random inputs -> every registered output and status = 0.
2. ADDS, forwarding: reg1In=5, sel1=1, fwdMem=0x7FFFFFFF, immIn=1, so=0x001, aluCmd=0010, sIn=1 -> next cycle aluResOut=0x80000000, status=4'b1001 (N=1, V=1).
3. SUBS to zero, then SBC: A=3, Val2=3, aluCmd=0100, sIn=1 -> aluResOut=0, status=4'b0110. Next cycle SBC with A=10, Val2=4 -> aluResOut=6.
4. Immediate rotate and register shifts:
   - immIn=1, so=0x4FF -> Val2=0xFF000000.
   - immIn=0, Rm=0x80000000, so={5'd4,2'b10,1'b0,4'd0} (ASR 4) -> Val2=0xF8000000.
   - ROR 8 of 0x000000AB -> 0xAB000000.
5. Freeze: assert freeze for 3 cycles while inputs change, including sIn=1 -> outputs and status frozen. Release -> the current inputs load on the next edge.
6. Branch and memory address: pcIn=0x100, imm24In=-2 -> branchAddr=0xF8. LDR with reg1In=0x400, so=0x00C -> aluResOut=0x40C, memReadOut=1, status unchanged.
